// File: rtl/ads131_pkg.sv
// Shared types and constants for the ADS131A0x frame assembly path.
package ads131_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_STATUS   = 2'd1,
      ST_CHAN     = 2'd2,
      ST_WAIT_END = 2'd3
   } fsm_state_t;

   // Device word sizes selectable through the M1 pin strap.
   localparam int WORD_16 = 16;
   localparam int WORD_24 = 24;
   localparam int WORD_32 = 32;

   localparam logic [15:0] STAT_READY    = 16'h2200;
   localparam logic [7:0]  STAT_READY_HI = 8'h22;

   localparam int DEFAULT_NUM_CH = 4;

endpackage

// File: rtl/ads131_frame_hold.sv
// Output holding register with valid/ready handshake, sequence numbering and
// a saturating count of frames dropped because the consumer was not ready.
module ads131_frame_hold
   import ads131_pkg::*;
#(
   parameter int NUM_CH    = DEFAULT_NUM_CH,
   parameter int WORD_BITS = WORD_16,
   parameter int OUT_BITS  = WORD_24
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load,
   input  logic [WORD_BITS-1:0]         load_status,
   input  logic [NUM_CH*OUT_BITS-1:0]   load_ch,
   input  logic                         frame_ready,
   output logic                         frame_valid,
   output logic [WORD_BITS-1:0]         status_word,
   output logic [NUM_CH*OUT_BITS-1:0]   ch_data,
   output logic [7:0]                   frame_seq,
   output logic [7:0]                   overrun_cnt
);

   logic [7:0] seq_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_valid <= 1'b0;
         status_word <= '0;
         ch_data     <= '0;
         frame_seq   <= '0;
         overrun_cnt <= '0;
         seq_cnt     <= '0;
      end else if (load) begin
         // A ready consumer frees the register in the same cycle, so reload.
         if (!frame_valid || frame_ready) begin
            frame_valid <= 1'b1;
            status_word <= load_status;
            ch_data     <= load_ch;
            frame_seq   <= seq_cnt;
            seq_cnt     <= seq_cnt + 8'd1;
         end else if (overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
      end else if (frame_valid && frame_ready) begin
         frame_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ads131_frame_assembler.sv
// Rebuilds status + NUM_CH channel frames from the SPI master's word stream,
// checks frame length and hands complete frames to the output hold register.
module ads131_frame_assembler
   import ads131_pkg::*;
#(
   parameter int NUM_CH    = DEFAULT_NUM_CH,
   parameter int WORD_BITS = WORD_16,
   parameter int OUT_BITS  = WORD_24
) (
   input  logic                         system_clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         frame_start,
   input  logic                         word_valid,
   input  logic [WORD_BITS-1:0]         word_data,
   input  logic                         frame_end,
   output logic                         frame_valid,
   input  logic                         frame_ready,
   output logic [WORD_BITS-1:0]         status_word,
   output logic [NUM_CH*OUT_BITS-1:0]   ch_data,
   output logic [7:0]                   frame_seq,
   output logic                         err_len,
   output logic [7:0]                   overrun_cnt
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   fsm_state_t                  state;
   logic [IDX_W-1:0]            ch_idx;
   logic [WORD_BITS-1:0]        shadow_status;
   logic [WORD_BITS-1:0]        shadow_ch [NUM_CH];

   logic                        last_word;
   logic                        commit;
   logic [WORD_BITS-1:0]        chan_word;
   logic [NUM_CH*OUT_BITS-1:0]  commit_ch;

   // The final channel word may arrive together with frame_end; it is taken
   // straight from word_data since the shadow slot only updates at the edge.
   always_comb begin
      last_word = (state == ST_CHAN) && word_valid && (ch_idx == IDX_W'(NUM_CH - 1));
      commit    = enable && frame_end && !frame_start &&
                  (last_word || ((state == ST_WAIT_END) && !word_valid));
      chan_word = '0;
      commit_ch = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         chan_word = (last_word && (int'(i) == NUM_CH - 1)) ? word_data : shadow_ch[i];
         commit_ch[i*OUT_BITS +: OUT_BITS] = OUT_BITS'($signed(chan_word));
      end
   end

   always_ff @(posedge system_clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         ch_idx        <= '0;
         err_len       <= 1'b0;
         shadow_status <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) shadow_ch[i] <= '0;
      end else begin
         err_len <= 1'b0;
         if (!enable) begin
            state  <= ST_IDLE;
            ch_idx <= '0;
         end else if (frame_start) begin
            err_len <= (state != ST_IDLE);
            state   <= ST_STATUS;
            ch_idx  <= '0;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_STATUS: begin
                  if (word_valid) begin
                     shadow_status <= word_data;
                     ch_idx        <= '0;
                     state         <= frame_end ? ST_IDLE : ST_CHAN;
                     err_len       <= frame_end;
                  end else if (frame_end) begin
                     state   <= ST_IDLE;
                     err_len <= 1'b1;
                  end
               end
               ST_CHAN: begin
                  if (word_valid) begin
                     shadow_ch[ch_idx] <= word_data;
                     if (last_word) begin
                        state <= frame_end ? ST_IDLE : ST_WAIT_END;
                     end else begin
                        ch_idx <= ch_idx + 1'b1;
                        if (frame_end) begin
                           state   <= ST_IDLE;
                           err_len <= 1'b1;
                        end
                     end
                  end else if (frame_end) begin
                     state   <= ST_IDLE;
                     err_len <= 1'b1;
                  end
               end
               ST_WAIT_END: begin
                  if (word_valid) begin
                     state   <= ST_IDLE;
                     err_len <= 1'b1;
                  end else if (frame_end) begin
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   ads131_frame_hold #(
      .NUM_CH    (NUM_CH),
      .WORD_BITS (WORD_BITS),
      .OUT_BITS  (OUT_BITS)
   ) u_hold (
      .clk         (system_clock),
      .reset       (reset),
      .load        (commit),
      .load_status (shadow_status),
      .load_ch     (commit_ch),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .status_word (status_word),
      .ch_data     (ch_data),
      .frame_seq   (frame_seq),
      .overrun_cnt (overrun_cnt)
   );

endmodule

// File: tb/tb_ads131_frame_assembler.sv
// Scoreboard bench for ads131_frame_assembler (NUM_CH=4, 16-bit words, 24-bit channels).
module tb_ads131_frame_assembler;

   logic        clk = 1'b0;
   logic        reset, enable, frame_start, word_valid, frame_end, frame_ready;
   logic [15:0] word_data;
   logic        frame_valid, err_len;
   logic [15:0] status_word;
   logic [95:0] ch_data;
   logic [7:0]  frame_seq, overrun_cnt;

   ads131_frame_assembler #(
      .NUM_CH    (4),
      .WORD_BITS (16),
      .OUT_BITS  (24)
   ) dut (
      .system_clock (clk),
      .reset        (reset),
      .enable       (enable),
      .frame_start  (frame_start),
      .word_valid   (word_valid),
      .word_data    (word_data),
      .frame_end    (frame_end),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .status_word  (status_word),
      .ch_data      (ch_data),
      .frame_seq    (frame_seq),
      .err_len      (err_len),
      .overrun_cnt  (overrun_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] st;
      logic [95:0] ch;
      logic [7:0]  seq;
   } exp_t;

   exp_t       sbq[$];
   int         checks   = 0;
   int         errors   = 0;
   int         err_seen = 0;
   int         err0;
   logic [7:0] exp_seq  = '0;

   function automatic logic [23:0] sx(input logic [15:0] w);
      return {{8{w[15]}}, w};
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare each accepted frame against the scoreboard head.
   always @(negedge clk) begin
      if (!reset) begin
         if (err_len) err_seen++;
         if (frame_valid && frame_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame seq %0d expected none", frame_seq);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("status", {80'd0, status_word}, {80'd0, e.st});
               chk("ch_data", ch_data, e.ch);
               chk("seq", {88'd0, frame_seq}, {88'd0, e.seq});
            end
         end
      end
   end

   task automatic cyc(input logic fs, input logic wv, input logic [15:0] wd, input logic fe);
      frame_start = fs; word_valid = wv; word_data = wd; frame_end = fe;
      @(posedge clk); #1;
      frame_start = 1'b0; word_valid = 1'b0; word_data = '0; frame_end = 1'b0;
   endtask

   task automatic push_exp(input logic [15:0] s, a, b, c, d);
      sbq.push_back({s, sx(d), sx(c), sx(b), sx(a), exp_seq});
      exp_seq++;
   endtask

   task automatic body(input logic [15:0] s, a, b, c, d);
      cyc(1, 0, 0, 0);
      cyc(0, 1, s, 0); cyc(0, 1, a, 0); cyc(0, 1, b, 0); cyc(0, 1, c, 0); cyc(0, 1, d, 0);
   endtask

   task automatic frame(input logic [15:0] s, a, b, c, d, input logic push);
      if (push) push_exp(s, a, b, c, d);
      body(s, a, b, c, d);
      cyc(0, 0, 0, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
      #1;
      chk("drain", 96'(sbq.size()), 96'd0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; frame_start = 1'b0; word_valid = 1'b0;
      word_data = '0; frame_end = 1'b0; frame_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {95'd0, frame_valid}, 96'd0);
      chk("rst_ch", ch_data, 96'd0);
      chk("rst_misc", {64'd0, status_word, frame_seq, overrun_cnt}, 96'd0);
      chk("rst_err", {95'd0, err_len}, 96'd0);
      reset = 1'b0;
      cyc(0, 0, 0, 0);

      // 1: nominal frame with hand-computed sign extension
      sbq.push_back({16'h2200, 24'hFFFFFF, 24'hFF8000, 24'h007FFF, 24'h000001, 8'd0});
      exp_seq = 8'd1;
      body(16'h2200, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF);
      chk("t1_valid_before_end", {95'd0, frame_valid}, 96'd0);
      cyc(0, 0, 0, 1);
      chk("t1_valid_after_end", {95'd0, frame_valid}, 96'd1);
      cyc(0, 0, 0, 0);
      chk("t1_valid_clears", {95'd0, frame_valid}, 96'd0);
      drain();

      // 2: short and long frames are dropped with one err_len pulse each
      err0 = err_seen;
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 16'(i), 0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      chk("t2_short_err", 96'(err_seen), 96'(err0 + 1));
      chk("t2_short_novalid", {95'd0, frame_valid}, 96'd0);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 16'(i), 0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      chk("t2_long_err", 96'(err_seen), 96'(err0 + 2));
      chk("t2_long_novalid", {95'd0, frame_valid}, 96'd0);
      frame(16'h2201, 16'h1234, 16'hFEDC, 16'h0000, 16'h8001, 1'b1);
      drain();

      // 3: backpressure drops the second frame
      frame_ready = 1'b0;
      frame(16'h2202, 16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 1'b1);
      frame(16'h2203, 16'hF111, 16'hF222, 16'hF333, 16'hF444, 1'b0);
      cyc(0, 0, 0, 0);
      chk("t3_overrun", {88'd0, overrun_cnt}, 96'd1);
      chk("t3_held", {95'd0, frame_valid}, 96'd1);
      frame_ready = 1'b1;
      cyc(0, 0, 0, 0);
      chk("t3_accept_clears", {95'd0, frame_valid}, 96'd0);
      drain();

      // 4: ready in the commit cycle accepts the held frame and reloads
      frame_ready = 1'b0;
      frame(16'h2204, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 1'b1);
      push_exp(16'h2205, 16'h9999, 16'h7777, 16'h5555, 16'h3333);
      body(16'h2205, 16'h9999, 16'h7777, 16'h5555, 16'h3333);
      frame_ready = 1'b1;
      cyc(0, 0, 0, 1);
      chk("t4_valid_stays", {95'd0, frame_valid}, 96'd1);
      chk("t4_overrun_same", {88'd0, overrun_cnt}, 96'd1);
      drain();

      // 5: restart mid-frame, then same-cycle last word and frame_end
      err0 = err_seen;
      cyc(1, 0, 0, 0); cyc(0, 1, 16'h1111, 0); cyc(0, 1, 16'h2222, 0);
      frame(16'h2206, 16'h4000, 16'hC000, 16'h0FFF, 16'hF000, 1'b1);
      drain();
      chk("t5_abort_err", 96'(err_seen), 96'(err0 + 1));
      push_exp(16'h2207, 16'h0010, 16'h0020, 16'h0030, 16'h8040);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 16'h2207, 0); cyc(0, 1, 16'h0010, 0); cyc(0, 1, 16'h0020, 0);
      cyc(0, 1, 16'h0030, 0);
      cyc(0, 1, 16'h8040, 1);
      chk("t5_same_cycle_commit", {95'd0, frame_valid}, 96'd1);
      drain();
      chk("t5_no_extra_err", 96'(err_seen), 96'(err0 + 1));

      // enable low discards a partial frame silently
      cyc(1, 0, 0, 0); cyc(0, 1, 16'h5555, 0); cyc(0, 1, 16'h6666, 0);
      enable = 1'b0;
      cyc(0, 1, 16'h7777, 1);
      enable = 1'b1;
      frame(16'h2208, 16'h0042, 16'hFFFE, 16'h7FFE, 16'h8002, 1'b1);
      drain();
      chk("en_no_err", 96'(err_seen), 96'(err0 + 1));

      // 6: reset mid-frame with a frame held
      frame_ready = 1'b0;
      frame(16'h2209, 16'h1357, 16'h2468, 16'h3579, 16'h468A, 1'b0);
      cyc(1, 0, 0, 0); cyc(0, 1, 16'h2200, 0); cyc(0, 1, 16'h0001, 0);
      reset = 1'b1;
      cyc(0, 0, 0, 0);
      chk("t6_rst_valid", {95'd0, frame_valid}, 96'd0);
      chk("t6_rst_ch", ch_data, 96'd0);
      chk("t6_rst_misc", {64'd0, status_word, frame_seq, overrun_cnt}, 96'd0);
      reset = 1'b0;
      sbq.delete();
      exp_seq = '0;
      frame_ready = 1'b1;
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 257; i++)
         frame(16'h2200, 16'(i), ~16'(i), 16'(i * 3), 16'h8000 ^ 16'(i), 1'b1);
      drain();

      frame_ready = 1'b0;
      frame(16'h22AA, 16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 1'b1);
      for (int i = 0; i < 260; i++)
         frame(16'h22BB, 16'(i), 16'(i), 16'(i), 16'(i), 1'b0);
      chk("t6_overrun_sat", {88'd0, overrun_cnt}, 96'd255);
      frame_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
